// File: rtl/video_timing_detector.sv
// Measures incoming hsync/vsync/de timing per frame, locks after LOCK_FRAMES identical
// frames and recovers the active pixel position for downstream capture logic.
module video_timing_detector #(
  parameter int H_W         = 12,
  parameter int V_W         = 11,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic           clk_pix,
  input  logic           rst,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           de,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_active,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] v_active,
  output logic           locked,
  output logic           pix_valid,
  output logic [H_W-1:0] pix_x,
  output logic [V_W-1:0] pix_y
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t          state, state_n;
  logic            hs_q, vs_q, de_q;
  logic [H_W-1:0]  hcnt, runcnt, f_hper, f_hact;
  logic [V_W-1:0]  f_lines, f_runs;
  logic            f_have_h, f_have_r, f_bad;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      match_cnt, mc_n;
  logic            first_pend, locked_n, commit;

  logic            h_rise, v_rise, de_rise, de_fall, timeout_hit, match;
  logic [H_W-1:0]  line_per, n_hper, n_hact;
  logic [V_W-1:0]  n_lines, n_runs;
  logic            n_have_h, n_have_r, n_bad;

  assign h_rise   = hsync & ~hs_q;
  assign v_rise   = vsync & ~vs_q;
  assign de_rise  = de & ~de_q;
  assign de_fall  = ~de & de_q;
  assign line_per = (&hcnt) ? hcnt : hcnt + 1'b1;
  assign timeout_hit = !h_rise && (to_cnt == TO_W'(TIMEOUT - 1));

  // Frame statistics including this cycle's events, so a v_rise commit sees
  // an h_rise/de edge that lands in the same cycle.
  always_comb begin
    n_hper   = f_hper;
    n_hact   = f_hact;
    n_have_h = f_have_h;
    n_have_r = f_have_r;
    n_lines  = f_lines;
    n_runs   = f_runs;
    n_bad    = f_bad;
    if (h_rise) begin
      if (!f_have_h) begin
        n_hper   = line_per;
        n_have_h = 1'b1;
      end else if (line_per != f_hper) n_bad = 1'b1;
      if (&line_per) n_bad = 1'b1;
      if (!(&f_lines)) n_lines = f_lines + 1'b1;
      if (&n_lines) n_bad = 1'b1;
    end
    if (de_fall) begin
      if (!f_have_r) begin
        n_hact   = runcnt;
        n_have_r = 1'b1;
      end else if (runcnt != f_hact) n_bad = 1'b1;
      if (&runcnt) n_bad = 1'b1;
    end
    if (de_rise) begin
      if (!(&f_runs)) n_runs = f_runs + 1'b1;
      if (&n_runs) n_bad = 1'b1;
    end
  end

  assign match = !n_bad && (n_hper != '0) && (n_hact != '0) && (n_lines != '0) &&
                 (n_runs != '0) && (n_hper == h_total) && (n_hact == h_active) &&
                 (n_lines == v_total) && (n_runs == v_active);

  always_comb begin
    state_n  = state;
    locked_n = locked;
    mc_n     = match_cnt;
    commit   = 1'b0;
    case (state)
      SEARCH: if (v_rise) begin
        state_n = MEASURE;
        mc_n    = '0;
      end
      MEASURE: if (v_rise) begin
        commit = 1'b1;
        if (!match) mc_n = '0;
        else if ({1'b0, match_cnt} + 5'd1 >= 5'(LOCK_FRAMES - 1)) begin
          state_n  = LOCKED;
          locked_n = 1'b1;
        end else mc_n = match_cnt + 4'd1;
      end
      LOCKED: if (v_rise) begin
        commit = 1'b1;
        if (!match) begin
          state_n  = MEASURE;
          locked_n = 1'b0;
          mc_n     = '0;
        end
      end
      default: state_n = SEARCH;
    endcase
    // Loss of hsync overrides everything; committed values are kept.
    if (timeout_hit) begin
      state_n  = SEARCH;
      locked_n = 1'b0;
      mc_n     = '0;
      commit   = 1'b0;
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      {hs_q, vs_q, de_q} <= '0;
      hcnt <= '0; runcnt <= '0; f_hper <= '0; f_hact <= '0;
      f_lines <= '0; f_runs <= '0; f_have_h <= 1'b0; f_have_r <= 1'b0; f_bad <= 1'b0;
      to_cnt <= '0; match_cnt <= '0; first_pend <= 1'b0; locked <= 1'b0;
      h_total <= '0; h_active <= '0; v_total <= '0; v_active <= '0;
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0;
    end else begin
      state     <= state_n;
      locked    <= locked_n;
      match_cnt <= mc_n;
      hs_q <= hsync;
      vs_q <= vsync;
      de_q <= de;
      if (h_rise) hcnt <= '0;
      else if (!(&hcnt)) hcnt <= hcnt + 1'b1;
      if (de_rise) runcnt <= H_W'(1);
      else if (de && !(&runcnt)) runcnt <= runcnt + 1'b1;
      if (h_rise) to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
      if (commit) begin
        h_total  <= n_hper;
        h_active <= n_hact;
        v_total  <= n_lines;
        v_active <= n_runs;
      end
      if (v_rise) begin
        f_hper <= '0; f_hact <= '0; f_lines <= '0; f_runs <= '0;
        f_have_h <= 1'b0; f_have_r <= 1'b0; f_bad <= 1'b0;
      end else begin
        f_hper <= n_hper; f_hact <= n_hact; f_lines <= n_lines; f_runs <= n_runs;
        f_have_h <= n_have_h; f_have_r <= n_have_r; f_bad <= n_bad;
      end
      pix_valid <= de;
      if (de) pix_x <= de_rise ? '0 : pix_x + 1'b1;
      if (de_rise) pix_y <= (first_pend || v_rise) ? '0 : pix_y + 1'b1;
      if (de_rise) first_pend <= 1'b0;
      else if (v_rise) first_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: a scaled-down raster (40x20, active 32x15) keeps
// frames short; a pixel scoreboard checks every pix_valid cycle.
module tb_video_timing_detector;
  localparam int HT = 40, HA = 32, HS0 = 34, HS1 = 36, VT = 20, VA = 15, VS0 = 17;
  localparam logic [45:0] M_STD = {12'd40, 12'd32, 11'd20, 11'd15};

  typedef struct packed { logic [11:0] x; logic [10:0] y; } pix_t;

  logic        clk_pix = 1'b0, rst = 1'b1, hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [11:0] h_total, h_active, pix_x;
  logic [10:0] v_total, v_active, pix_y;
  logic        locked, pix_valid;

  video_timing_detector dut (
    .clk_pix(clk_pix), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y)
  );

  always #5 clk_pix = ~clk_pix;

  int   total = 0, bad = 0;
  int   gx = 0, gy = 0;
  bit   coinc = 0, short_pend = 0;
  logic pv = 0, pd = 0, drv_vr = 0, pend = 0;
  logic [11:0] xm = 0;
  logic [10:0] ym = 0;
  pix_t q[$];

  function automatic logic [45:0] meas();
    return {h_total, h_active, v_total, v_active};
  endfunction

  // Drive one cycle, predict the pixel it produces, then check the output one cycle later.
  task automatic cyc(input logic h, input logic v, input logic d);
    pix_t e;
    drv_vr = v & ~pv;
    if (drv_vr) pend = 1'b1;
    if (d & ~pd) begin
      ym = pend ? 11'd0 : ym + 11'd1;
      pend = 1'b0;
      xm = 12'd0;
    end else if (d) xm = xm + 12'd1;
    if (d) q.push_back({xm, ym});
    pv = v; pd = d;
    hsync = h; vsync = v; de = d;
    @(negedge clk_pix);
    total++;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (pix_valid !== 1'b1 || pix_x !== e.x || pix_y !== e.y) begin
        bad++;
        $display("FAIL pixel: got valid=%b x=%0d y=%0d, want valid=1 x=%0d y=%0d",
                 pix_valid, pix_x, pix_y, e.x, e.y);
      end
    end else if (pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL pixel_idle: got valid=%b, want 0", pix_valid);
    end
  endtask

  task automatic gen_cycle();
    int len, vsx;
    logic h, v, d;
    len = (short_pend && gy == 16) ? HT - 1 : HT;
    vsx = coinc ? HS0 : 0;
    h = (gx >= HS0 && gx <= HS1);
    v = (gy == VS0 && gx >= vsx) || (gy == VS0 + 1) || (gy == VS0 + 2 && gx < vsx);
    d = (gx < HA && gy < VA);
    cyc(h, v, d);
    gx++;
    if (gx == len) begin
      gx = 0;
      if (short_pend && gy == 16) short_pend = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic run_until_vrise(input string tag);
    int n = 0;
    do begin gen_cycle(); n++; end while (!drv_vr && n < 2000);
    if (!drv_vr) begin
      total++; bad++;
      $display("FAIL %s: no vsync rise within 2000 cycles", tag);
    end
  endtask

  task automatic run_to(input int y, input int x);
    int n = 0;
    while (!(gy == y && gx == x) && n < 2000) begin gen_cycle(); n++; end
    if (!(gy == y && gx == x)) begin
      total++; bad++;
      $display("FAIL run_to: position %0d,%0d not reached", y, x);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_pix);
    total++;
    if ({meas(), locked, pix_valid, pix_x, pix_y} !== '0) begin
      bad++;
      $display("FAIL reset: got %h, want 0", {meas(), locked, pix_valid, pix_x, pix_y});
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    run_until_vrise("lock1");
    total++;
    if ({meas(), locked} !== '0) begin
      bad++; $display("FAIL lock_search: got %h, want 0 (no commit)", {meas(), locked});
    end
    run_until_vrise("lock2");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b0}) begin
      bad++; $display("FAIL lock_first: got %h, want %h", {meas(), locked}, {M_STD, 1'b0});
    end
    run_until_vrise("lock3");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b1}) begin
      bad++; $display("FAIL lock_second: got %h, want %h", {meas(), locked}, {M_STD, 1'b1});
    end
  endtask

  task automatic test_position();
    run_to(0, 0);
    gen_cycle();
    total++;
    if ({pix_valid, pix_x, pix_y} !== {1'b1, 12'd0, 11'd0}) begin
      bad++; $display("FAIL pos_first: got v=%b x=%0d y=%0d, want 1 0 0", pix_valid, pix_x, pix_y);
    end
    run_to(VA - 1, HA - 1);
    gen_cycle();
    total++;
    if ({pix_valid, pix_x, pix_y} !== {1'b1, 12'd31, 11'd14}) begin
      bad++; $display("FAIL pos_last: got v=%b x=%0d y=%0d, want 1 31 14", pix_valid, pix_x, pix_y);
    end
    gen_cycle();
    total++;
    if ({pix_valid, pix_x, pix_y} !== {1'b0, 12'd31, 11'd14}) begin
      bad++; $display("FAIL pos_hold: got v=%b x=%0d y=%0d, want 0 31 14", pix_valid, pix_x, pix_y);
    end
  endtask

  task automatic test_short_line();
    short_pend = 1;
    run_until_vrise("short0");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b1}) begin
      bad++; $display("FAIL short_before: got %h, want %h", {meas(), locked}, {M_STD, 1'b1});
    end
    run_until_vrise("short1");
    total++;
    if ({meas(), locked} !== {12'd39, 12'd32, 11'd20, 11'd15, 1'b0}) begin
      bad++; $display("FAIL short_commit: got %h, want %h", {meas(), locked},
                      {12'd39, 12'd32, 11'd20, 11'd15, 1'b0});
    end
    run_until_vrise("short2");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b0}) begin
      bad++; $display("FAIL short_good1: got %h, want %h", {meas(), locked}, {M_STD, 1'b0});
    end
    run_until_vrise("short3");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b1}) begin
      bad++; $display("FAIL short_relock: got %h, want %h", {meas(), locked}, {M_STD, 1'b1});
    end
  endtask

  task automatic test_timeout();
    run_to(1, 0);
    repeat (4000) cyc(1'b0, 1'b0, 1'b0);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL timeout_early: got locked=%b, want 1", locked);
    end
    repeat (100) cyc(1'b0, 1'b0, 1'b0);
    total++;
    if ({meas(), locked} !== {M_STD, 1'b0}) begin
      bad++; $display("FAIL timeout_drop: got %h, want %h", {meas(), locked}, {M_STD, 1'b0});
    end
    run_until_vrise("timeout1");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b0}) begin
      bad++; $display("FAIL timeout_search: got %h, want %h", {meas(), locked}, {M_STD, 1'b0});
    end
    run_until_vrise("timeout2");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b1}) begin
      bad++; $display("FAIL timeout_relock: got %h, want %h", {meas(), locked}, {M_STD, 1'b1});
    end
  endtask

  task automatic test_mid_reset();
    run_to(5, 10);
    rst = 1'b1;
    #1;
    total++;
    if ({meas(), locked, pix_valid, pix_x, pix_y} !== '0) begin
      bad++; $display("FAIL midrst_clear: got %h, want 0", {meas(), locked, pix_valid, pix_x, pix_y});
    end
    q.delete();
    xm = 0; ym = 0; pend = 0; pv = 0; pd = 0;
    repeat (2) @(negedge clk_pix);
    rst = 1'b0;
    run_until_vrise("midrst1");
    total++;
    if ({meas(), locked} !== '0) begin
      bad++; $display("FAIL midrst_search: got %h, want 0", {meas(), locked});
    end
    run_until_vrise("midrst2");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b0}) begin
      bad++; $display("FAIL midrst_first: got %h, want %h", {meas(), locked}, {M_STD, 1'b0});
    end
    run_until_vrise("midrst3");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b1}) begin
      bad++; $display("FAIL midrst_relock: got %h, want %h", {meas(), locked}, {M_STD, 1'b1});
    end
  endtask

  // vsync now rises together with hsync; the switch-over frame gains one line.
  task automatic test_coincident();
    run_to(1, 0);
    coinc = 1;
    run_until_vrise("coinc1");
    total++;
    if ({meas(), locked} !== {12'd40, 12'd32, 11'd21, 11'd15, 1'b0}) begin
      bad++; $display("FAIL coinc_switch: got %h, want %h", {meas(), locked},
                      {12'd40, 12'd32, 11'd21, 11'd15, 1'b0});
    end
    run_until_vrise("coinc2");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b0}) begin
      bad++; $display("FAIL coinc_vtotal: got %h, want %h", {meas(), locked}, {M_STD, 1'b0});
    end
    run_until_vrise("coinc3");
    total++;
    if ({meas(), locked} !== {M_STD, 1'b1}) begin
      bad++; $display("FAIL coinc_lock: got %h, want %h", {meas(), locked}, {M_STD, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_position();
    test_short_line();
    test_timeout();
    test_mid_reset();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
